hazard_controller: RTL and testbench
====================================

Name: hazard_controller

Overview:
- Hazard and scheduling controller for the 5-stage pipelined MIPS datapath.
- Produces the per-stage control: fetch/decode stalls, execute flush, and decode/execute forwarding selects.
- Owns the sequencing of the shared multi-cycle multiplier: tracks a busy state, holds HI/LO readers and back-to-back multiplies in decode, runs a timeout watchdog and keeps a saturating stall-cycle counter.

Parameters:
MULT_TIMEOUT, 64, cycles after MultStartE without MultDoneE before multErr asserts
CNT_W, 16, width of stallCount

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
RsD  in  5  decode source register A
RtD  in  5  decode source register B
branchD  in  2  00 none, 01 beq, 10 bne, 11 reserved (treated as branch)
WBSrcD  in  3  decode writeback source
MultStartD  in  1  multiply instruction in decode
RsE  in  5  execute source register A
RtE  in  5  execute source register B
WriteRegE  in  5  execute destination register
RegWriteE  in  1  execute writes register file
WBSrcE  in  3  execute writeback source
MultStartE  in  1  multiplier launch, execute stage
MultDoneE  in  1  multiplier completion pulse
WriteRegM  in  5  memory-stage destination
RegWriteM  in  1  memory-stage writes register file
WBSrcM  in  3  memory-stage writeback source
WriteRegW  in  5  writeback destination
RegWriteW  in  1  writeback writes register file
stallF  out  1  hold PC
stallD  out  1  hold F/D register
forwardAD  out  1  decode A from ALUMultOutM
forwardBD  out  1  decode B from ALUMultOutM
flushE  out  1  bubble into E
forwardAE  out  2  00 regfile, 10 from M, 01 from W
forwardBE  out  2  same encoding, B operand
multBusy  out  1  registered multiplier busy
multErr  out  1  sticky timeout flag
stallCount  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- WBSrc encoding: 000 ALU, 001 memory, 010 HI, 011 LO, 100 PC+8.
- Register $0 never matches any hazard or forward comparison.
- Execute forwarding, combinational, for A (B identical using RtE):
  - forwardAE=10 if RegWriteM and WriteRegM==RsE;
  - else 01 if RegWriteW and WriteRegW==RsE;
  - else 00.
  - M has priority over W.
- Decode forwarding: forwardAD = RegWriteM and WriteRegM==RsD; forwardBD likewise with RtD.
- lwStall = (WBSrcE==001) and (RsD==WriteRegE or RtD==WriteRegE).
- brStall = branchD!=00 and either:
  - RegWriteE and WriteRegE in {RsD,RtD}; or
  - WBSrcM==001 and WriteRegM in {RsD,RtD}.
- multStall = multBusy and not MultDoneE and (WBSrcD in {010,011} or MultStartD).
- stall = lwStall or brStall or multStall.
- stallF = stallD = flushE = stall, all combinational in the same cycle (zero latency).
- Multiplier FSM, states IDLE and BUSY:
  - IDLE→BUSY on MultStartE; the watchdog counter loads 0.
  - BUSY→IDLE on MultDoneE.
  - MultStartE and MultDoneE in the same cycle while BUSY: stay BUSY and reload the counter to 0 (new operation).
  - MultDoneE while IDLE is ignored.
  - In BUSY the counter increments each cycle. When it reaches MULT_TIMEOUT-1, multErr sets (sticky until rst) and the FSM returns to IDLE.
  - multBusy = (state==BUSY), registered.
- stallCount: increments when stall=1, saturates at all-ones, never wraps.
- Reset: state IDLE, watchdog 0, multBusy 0, multErr 0, stallCount 0. A mid-operation reset abandons the multiply with no error.
- Outputs under reset: combinational outputs still follow their inputs. The pipeline stage registers are themselves reset, so they present no hazards.

Test Plan:
- Forwarding: RegWriteM=1, WriteRegM=5, RegWriteW=1, WriteRegW=5, RsE=5 → forwardAE=10. Then RegWriteM=0 → forwardAE=01. Then RsE=0 with both writers targeting 0 → forwardAE=00.
- Load-use: WBSrcE=001, WriteRegE=8, RtD=8 → stallF=stallD=flushE=1 for one cycle; stallCount 0→1. Next cycle WBSrcE=000 → stall 0.
- Branch: branchD=01, RsD=3, RegWriteE=1, WriteRegE=3 → stall=1. Then WriteRegM=3, RegWriteM=1, WBSrcM=000 → stall=0, forwardAD=1. WBSrcM=001 → stall=1.
- Multiplier: MultStartE pulse → multBusy=1 next cycle. WBSrcD=010 → stall held each cycle. MultDoneE pulse → stall 0 that cycle; multBusy=0 the following cycle. MultStartD while busy also stalls.
- Timeout: MULT_TIMEOUT=8, MultStartE with no MultDoneE → multErr=1 eight cycles later, multBusy=0. multErr persists until rst=1, which clears all state the next edge.
- Saturation: CNT_W=4, hold stall for 20 cycles → stallCount reads 15 and stays 15.

Source files
------------

// File: rtl/hazard_controller.sv
// hazard_controller
//   Hazard and scheduling controller for the 5-stage pipelined MIPS datapath.
//   Generates fetch/decode stalls, the execute flush, and decode/execute
//   forwarding selects. Also sequences the shared multi-cycle multiplier:
//   a registered busy state, a timeout watchdog with a sticky error flag,
//   and a saturating count of stalled cycles.
//
// Parameters
//   MULT_TIMEOUT  cycles after MultStartE without MultDoneE before multErr
//   CNT_W         width of stallCount
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   RsD, RtD, branchD, WBSrcD,   decode-stage operands, branch type,
//   MultStartD                   writeback source, multiply-in-decode
//   RsE, RtE, WriteRegE,         execute-stage operands, destination,
//   RegWriteE, WBSrcE            write enable, writeback source
//   MultStartE, MultDoneE        multiplier launch / completion pulse
//   WriteRegM, RegWriteM, WBSrcM memory-stage destination / enable / source
//   WriteRegW, RegWriteW         writeback-stage destination / enable
//   stallF, stallD, flushE       pipeline hold / bubble controls
//   forwardAD, forwardBD         decode operand bypass from memory stage
//   forwardAE, forwardBE         execute operand select (10 M, 01 W, 00 RF)
//   multBusy, multErr            multiplier busy, sticky timeout flag
//   stallCount                   saturating stalled-cycle counter

module hazard_controller #(
  parameter int MULT_TIMEOUT = 64,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       RsD,
  input  logic [4:0]       RtD,
  input  logic [1:0]       branchD,
  input  logic [2:0]       WBSrcD,
  input  logic             MultStartD,
  input  logic [4:0]       RsE,
  input  logic [4:0]       RtE,
  input  logic [4:0]       WriteRegE,
  input  logic             RegWriteE,
  input  logic [2:0]       WBSrcE,
  input  logic             MultStartE,
  input  logic             MultDoneE,
  input  logic [4:0]       WriteRegM,
  input  logic             RegWriteM,
  input  logic [2:0]       WBSrcM,
  input  logic [4:0]       WriteRegW,
  input  logic             RegWriteW,
  output logic             stallF,
  output logic             stallD,
  output logic             forwardAD,
  output logic             forwardBD,
  output logic             flushE,
  output logic [1:0]       forwardAE,
  output logic [1:0]       forwardBE,
  output logic             multBusy,
  output logic             multErr,
  output logic [CNT_W-1:0] stallCount
);

  localparam int              WD_W    = (MULT_TIMEOUT > 1) ? $clog2(MULT_TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MULT_TIMEOUT - 1);

  localparam logic [2:0] WB_MEM = 3'b001;
  localparam logic [2:0] WB_HI  = 3'b010;
  localparam logic [2:0] WB_LO  = 3'b011;

  typedef enum logic {IDLE, BUSY} multState_t;

  multState_t      state;
  multState_t      nextState;
  logic [WD_W-1:0] wdCount;
  logic [WD_W-1:0] wdCountNext;
  logic            timeoutHit;

  logic lwStall;
  logic brStall;
  logic multStall;
  logic stall;

  // Register $0 is hard-wired to zero, so it never creates a dependency.
  function automatic logic regHit(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

  // ---------------------------------------------------------------------------
  // Forwarding
  // ---------------------------------------------------------------------------
  always_comb begin
    forwardAE = 2'b00;
    if (RegWriteM && regHit(WriteRegM, RsE))      forwardAE = 2'b10;
    else if (RegWriteW && regHit(WriteRegW, RsE)) forwardAE = 2'b01;

    forwardBE = 2'b00;
    if (RegWriteM && regHit(WriteRegM, RtE))      forwardBE = 2'b10;
    else if (RegWriteW && regHit(WriteRegW, RtE)) forwardBE = 2'b01;

    forwardAD = RegWriteM && regHit(WriteRegM, RsD);
    forwardBD = RegWriteM && regHit(WriteRegM, RtD);
  end

  // ---------------------------------------------------------------------------
  // Stall detection
  // ---------------------------------------------------------------------------
  always_comb begin
    lwStall = (WBSrcE == WB_MEM) &&
              (regHit(WriteRegE, RsD) || regHit(WriteRegE, RtD));

    // Branches resolve in decode: wait for an E-stage result, or for a load
    // still in M whose data cannot be bypassed yet.
    brStall = (branchD != 2'b00) &&
              ((RegWriteE && (regHit(WriteRegE, RsD) || regHit(WriteRegE, RtD))) ||
               ((WBSrcM == WB_MEM) && (regHit(WriteRegM, RsD) || regHit(WriteRegM, RtD))));

    // A completion pulse frees HI/LO in the same cycle, so the reader need not wait.
    multStall = multBusy && !MultDoneE &&
                ((WBSrcD == WB_HI) || (WBSrcD == WB_LO) || MultStartD);

    stall  = lwStall || brStall || multStall;
    stallF = stall;
    stallD = stall;
    flushE = stall;
  end

  // ---------------------------------------------------------------------------
  // Multiplier sequencer: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      wdCount <= '0;
      multErr <= 1'b0;
    end else begin
      state   <= nextState;
      wdCount <= wdCountNext;
      if (timeoutHit) multErr <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Multiplier sequencer: next state
  // ---------------------------------------------------------------------------
  // While busy, a launch (with or without a coincident done) starts a fresh
  // operation; a plain done wins over a timeout landing in the same cycle.
  always_comb begin
    nextState   = state;
    wdCountNext = wdCount;
    timeoutHit  = 1'b0;
    case (state)
      IDLE: begin
        if (MultStartE) begin
          nextState   = BUSY;
          wdCountNext = '0;
        end
      end
      BUSY: begin
        if (MultStartE) begin
          wdCountNext = '0;
        end else if (MultDoneE) begin
          nextState = IDLE;
        end else if (wdCount == WD_LAST) begin
          nextState  = IDLE;
          timeoutHit = 1'b1;
        end else begin
          wdCountNext = wdCount + WD_W'(1);
        end
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Multiplier sequencer: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    multBusy = (state == BUSY);
  end

  // ---------------------------------------------------------------------------
  // Saturating stall counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      stallCount <= '0;
    end else if (stall && (stallCount != '1)) begin
      stallCount <= stallCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller
//   Self-checking bench for hazard_controller with MULT_TIMEOUT=8, CNT_W=4.
//   Directed steps followed by randomized traffic, all compared against a
//   behavioural reference model held in the bench.

module tb_hazard_controller;

  localparam int TO   = 8;
  localparam int CW   = 4;
  localparam int SMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic [1:0]    branchD;
  logic [2:0]    WBSrcD, WBSrcE, WBSrcM;
  logic          MultStartD, RegWriteE, MultStartE, MultDoneE, RegWriteM, RegWriteW;
  logic          stallF, stallD, forwardAD, forwardBD, flushE, multBusy, multErr;
  logic [1:0]    forwardAE, forwardBE;
  logic [CW-1:0] stallCount;

  int nAssert = 0;
  int nFail   = 0;

  // Reference model state: busy flag, launch cycle, sticky error, stall count.
  bit mBusy;
  bit mErr;
  int mStart;
  int cycNo;
  int sCnt;

  hazard_controller #(.MULT_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .RsD(RsD), .RtD(RtD), .branchD(branchD), .WBSrcD(WBSrcD), .MultStartD(MultStartD),
    .RsE(RsE), .RtE(RtE), .WriteRegE(WriteRegE), .RegWriteE(RegWriteE), .WBSrcE(WBSrcE),
    .MultStartE(MultStartE), .MultDoneE(MultDoneE),
    .WriteRegM(WriteRegM), .RegWriteM(RegWriteM), .WBSrcM(WBSrcM),
    .WriteRegW(WriteRegW), .RegWriteW(RegWriteW),
    .stallF(stallF), .stallD(stallD), .forwardAD(forwardAD), .forwardBD(forwardBD),
    .flushE(flushE), .forwardAE(forwardAE), .forwardBE(forwardBE),
    .multBusy(multBusy), .multErr(multErr), .stallCount(stallCount)
  );

  always #5 clk = ~clk;

  function automatic bit hit(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

  function automatic logic [1:0] fwdE(input logic [4:0] src);
    if (RegWriteM && hit(WriteRegM, src)) return 2'b10;
    if (RegWriteW && hit(WriteRegW, src)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit expStall();
    bit lw, br, ml;
    lw = (WBSrcE == 3'b001) && (hit(WriteRegE, RsD) || hit(WriteRegE, RtD));
    br = (branchD != 2'b00) &&
         ((RegWriteE && (hit(WriteRegE, RsD) || hit(WriteRegE, RtD))) ||
          ((WBSrcM == 3'b001) && (hit(WriteRegM, RsD) || hit(WriteRegM, RtD))));
    ml = mBusy && !MultDoneE && (WBSrcD == 3'b010 || WBSrcD == 3'b011 || MultStartD);
    return lw || br || ml;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance the model across one clock edge using the inputs sampled there.
  task automatic modelEdge(input bit st);
    cycNo++;
    if (rst) begin
      mBusy = 1'b0;
      mErr  = 1'b0;
      sCnt  = 0;
    end else begin
      if (st) sCnt = (sCnt >= SMAX) ? SMAX : sCnt + 1;
      if (MultStartE) begin
        mBusy  = 1'b1;
        mStart = cycNo;
      end else if (mBusy && MultDoneE) begin
        mBusy = 1'b0;
      end else if (mBusy && (cycNo - mStart >= TO)) begin
        mErr  = 1'b1;
        mBusy = 1'b0;
      end
    end
  endtask

  task automatic clearIn();
    rst = 1'b0;
    RsD = '0; RtD = '0; branchD = '0; WBSrcD = '0; MultStartD = 1'b0;
    RsE = '0; RtE = '0; WriteRegE = '0; RegWriteE = 1'b0; WBSrcE = '0;
    MultStartE = 1'b0; MultDoneE = 1'b0;
    WriteRegM = '0; RegWriteM = 1'b0; WBSrcM = '0;
    WriteRegW = '0; RegWriteW = 1'b0;
  endtask

  // One clock: check combinational outputs, clock, check registered outputs.
  task automatic cycle();
    bit st;
    #1;
    st = expStall();
    chk("stallF", 32'(stallF), 32'(st));
    chk("stallD", 32'(stallD), 32'(st));
    chk("flushE", 32'(flushE), 32'(st));
    chk("forwardAD", 32'(forwardAD), 32'(RegWriteM && hit(WriteRegM, RsD)));
    chk("forwardBD", 32'(forwardBD), 32'(RegWriteM && hit(WriteRegM, RtD)));
    chk("forwardAE", 32'(forwardAE), 32'(fwdE(RsE)));
    chk("forwardBE", 32'(forwardBE), 32'(fwdE(RtE)));
    @(posedge clk);
    modelEdge(st);
    #1;
    chk("multBusy", 32'(multBusy), 32'(mBusy));
    chk("multErr", 32'(multErr), 32'(mErr));
    chk("stallCount", 32'(stallCount), 32'(sCnt));
  endtask

  initial begin
    clearIn();
    rst = 1'b1;
    @(posedge clk);
    #1;
    mBusy = 1'b0; mErr = 1'b0; sCnt = 0; cycNo = 0; mStart = 0;
    chk("rst_multBusy", 32'(multBusy), 32'd0);
    chk("rst_multErr", 32'(multErr), 32'd0);
    chk("rst_stallCount", 32'(stallCount), 32'd0);

    // Combinational paths stay live while reset is held.
    RegWriteM = 1'b1; WriteRegM = 5'd5; RsE = 5'd5;
    #1;
    chk("rst_fwdAE", 32'(forwardAE), 32'd2);
    cycle();

    // Execute forwarding priority and $0 exclusion.
    clearIn();
    RegWriteM = 1'b1; WriteRegM = 5'd5; RegWriteW = 1'b1; WriteRegW = 5'd5; RsE = 5'd5;
    #1; chk("fwdAE_M", 32'(forwardAE), 32'd2);
    RegWriteM = 1'b0;
    #1; chk("fwdAE_W", 32'(forwardAE), 32'd1);
    RegWriteM = 1'b1; RsE = 5'd0; WriteRegM = 5'd0; WriteRegW = 5'd0;
    #1; chk("fwdAE_r0", 32'(forwardAE), 32'd0);
    RtE = 5'd9; WriteRegW = 5'd9;
    #1; chk("fwdBE_W", 32'(forwardBE), 32'd1);
    cycle();

    // Load-use stall.
    clearIn();
    WBSrcE = 3'b001; WriteRegE = 5'd8; RtD = 5'd8;
    #1; chk("lw_stall", 32'({stallF, stallD, flushE}), 32'h7);
    cycle();
    chk("lw_count", 32'(stallCount), 32'd1);
    WBSrcE = 3'b000;
    #1; chk("lw_release", 32'(stallF), 32'd0);
    cycle();

    // Branch hazards.
    clearIn();
    branchD = 2'b01; RsD = 5'd3; RegWriteE = 1'b1; WriteRegE = 5'd3;
    #1; chk("br_E", 32'(stallD), 32'd1);
    cycle();
    RegWriteE = 1'b0; WriteRegE = 5'd0;
    WriteRegM = 5'd3; RegWriteM = 1'b1; WBSrcM = 3'b000;
    #1; chk("br_M_alu", 32'(stallD), 32'd0);
    chk("br_fwdAD", 32'(forwardAD), 32'd1);
    cycle();
    WBSrcM = 3'b001;
    #1; chk("br_M_load", 32'(stallD), 32'd1);
    cycle();
    chk("br_count", 32'(stallCount), 32'd3);

    // Multiplier busy / HI-LO readers / back-to-back multiply.
    clearIn();
    MultStartE = 1'b1;
    cycle();
    chk("mul_busy", 32'(multBusy), 32'd1);
    MultStartE = 1'b0; WBSrcD = 3'b010;
    for (int i = 0; i < 3; i++) begin
      #1; chk("mul_hold", 32'(stallF), 32'd1);
      cycle();
    end
    MultDoneE = 1'b1;
    #1; chk("mul_done_nostall", 32'(stallF), 32'd0);
    cycle();
    chk("mul_idle", 32'(multBusy), 32'd0);
    MultDoneE = 1'b0;
    cycle();
    WBSrcD = 3'b000; MultStartE = 1'b1;
    cycle();
    MultStartE = 1'b0; MultStartD = 1'b1;
    #1; chk("mul_b2b", 32'(stallD), 32'd1);
    cycle();
    MultStartE = 1'b1; MultDoneE = 1'b1;
    cycle();
    chk("mul_restart", 32'(multBusy), 32'd1);
    MultStartE = 1'b0; MultStartD = 1'b0;
    cycle();
    MultDoneE = 1'b0;
    cycle();

    // Watchdog timeout.
    clearIn();
    MultStartE = 1'b1;
    cycle();
    MultStartE = 1'b0;
    for (int i = 1; i < TO; i++) begin
      cycle();
      chk("to_pending", 32'({multBusy, multErr}), 32'h2);
    end
    cycle();
    chk("to_err", 32'({multBusy, multErr}), 32'h1);
    for (int i = 0; i < 3; i++) cycle();
    chk("to_sticky", 32'(multErr), 32'd1);
    MultDoneE = 1'b1;
    cycle();
    MultDoneE = 1'b0;
    rst = 1'b1;
    cycle();
    chk("to_rst", 32'({multBusy, multErr, 4'(stallCount)}), 32'd0);

    // Reset mid-operation abandons the multiply without an error.
    clearIn();
    MultStartE = 1'b1;
    cycle();
    MultStartE = 1'b0; rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < TO + 2; i++) cycle();
    chk("midrst_noerr", 32'(multErr), 32'd0);

    // Stall counter saturation.
    clearIn();
    WBSrcE = 3'b001; WriteRegE = 5'd4; RsD = 5'd4;
    for (int i = 0; i < 20; i++) cycle();
    chk("sat_15", 32'(stallCount), 32'd15);
    cycle();
    chk("sat_hold", 32'(stallCount), 32'd15);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      rst        = ($urandom_range(0, 63) == 0);
      RsD        = 5'($urandom_range(0, 3));
      RtD        = 5'($urandom_range(0, 3));
      branchD    = 2'($urandom_range(0, 3));
      WBSrcD     = 3'($urandom_range(0, 4));
      MultStartD = ($urandom_range(0, 3) == 0);
      RsE        = 5'($urandom_range(0, 3));
      RtE        = 5'($urandom_range(0, 3));
      WriteRegE  = 5'($urandom_range(0, 3));
      RegWriteE  = 1'($urandom_range(0, 1));
      WBSrcE     = 3'($urandom_range(0, 4));
      MultStartE = ($urandom_range(0, 9) == 0);
      MultDoneE  = ($urandom_range(0, 7) == 0);
      WriteRegM  = 5'($urandom_range(0, 3));
      RegWriteM  = 1'($urandom_range(0, 1));
      WBSrcM     = 3'($urandom_range(0, 4));
      WriteRegW  = 5'($urandom_range(0, 3));
      RegWriteW  = 1'($urandom_range(0, 1));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
